// File: rtl/dso_acq_ctrl.sv
// DSO acquisition sequencer: arm, pre-trigger fill, trigger wait (real/auto), post-trigger fill, hold for display.
// Optional post-arm trigger holdoff: define DSO_ACQ_HOLDOFF_EN to add the holdoff[15:0] input.
module dso_acq_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned AUTO_TO = 1_000_000,
    parameter int unsigned TO_W    = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wave_run,
    input  logic              single,
    input  logic              auto_en,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              smp_vld,
    input  logic              trig_in,
`ifdef DSO_ACQ_HOLDOFF_EN
    input  logic [15:0]       holdoff,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] rd_base,
    output logic              frame_rdy,
    input  logic              rd_over,
    output logic              trig_auto,
    output logic [2:0]        acq_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRE_FILL = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_POST     = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;

    // Pre-trigger length is clamped so at least one post-trigger sample remains.
    localparam logic [ADDR_W-1:0] PRE_MAX   = ADDR_W'((2 ** ADDR_W) - 2);
    localparam logic [ADDR_W-1:0] ADDR_ONES = '1;
    localparam logic [TO_W-1:0]   TO_LIM    = TO_W'(AUTO_TO);

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] pre_len_q,   pre_len_d;
    logic              single_q,    single_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;
    logic [TO_W-1:0]   to_q,        to_d;
    logic              pend_q,      pend_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_base_q,   rd_base_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              trig_auto_q, trig_auto_d;
`ifdef DSO_ACQ_HOLDOFF_EN
    logic [15:0]       ho_q,        ho_d;
`endif

    logic [ADDR_W-1:0] arm_len;
    logic [2:0]        arm_state;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] post_len;
    logic              trig_ok;
    logic              auto_fire;
    logic              abort;

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        pre_len_d   = pre_len_q;
        single_d    = single_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        pend_d      = pend_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        rd_base_d   = rd_base_q;
        frame_rdy_d = frame_rdy_q;
        trig_auto_d = trig_auto_q;
`ifdef DSO_ACQ_HOLDOFF_EN
        ho_d        = ho_q;
        trig_ok     = (ho_q == 16'd0);
`else
        trig_ok     = 1'b1;
`endif

        arm_len   = (pre_len > PRE_MAX) ? PRE_MAX : pre_len;
        arm_state = (arm_len == '0) ? S_ARMED : S_PRE_FILL;
        cnt_inc   = cnt_q + ADDR_W'(1);
        post_len  = ADDR_ONES - pre_len_q;
        auto_fire = pend_q | (auto_en & (to_q == TO_LIM));
        abort     = ~wave_run & ~single_q;

        case (state_q)
            S_IDLE: begin
                if (wave_run || single) begin
                    pre_len_d = arm_len;
                    single_d  = ~wave_run;
                    addr_d    = '0;
                    cnt_d     = '0;
                    state_d   = arm_state;
                end
            end

            S_PRE_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (smp_vld) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    cnt_d     = cnt_inc;
                    if (cnt_inc == pre_len_q) begin
                        cnt_d   = '0;
                        state_d = S_ARMED;
                    end
                end
            end

            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // Timeout saturates at the limit; auto-pending latches once reached.
                    if (trig_ok) begin
                        if (to_q != TO_LIM) begin
                            to_d = to_q + TO_W'(1);
                        end
                        if (auto_en && (to_q == TO_LIM)) begin
                            pend_d = 1'b1;
                        end
                    end
                    if (smp_vld) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + ADDR_W'(1);
                        if (trig_ok && (trig_in || auto_fire)) begin
                            trig_addr_d = addr_q;
                            rd_base_d   = addr_q - pre_len_q;
                            trig_auto_d = ~trig_in;
                            cnt_d       = '0;
                            state_d     = S_POST;
                        end
                    end
                end
            end

            S_POST: begin
                if (smp_vld) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    cnt_d     = cnt_inc;
                    if (cnt_inc == post_len) begin
                        frame_rdy_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (rd_over) begin
                    frame_rdy_d = 1'b0;
                    if (wave_run && !single_q) begin
                        pre_len_d = arm_len;
                        single_d  = 1'b0;
                        addr_d    = '0;
                        cnt_d     = '0;
                        state_d   = arm_state;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DSO_ACQ_HOLDOFF_EN
        if ((state_q == S_ARMED) && (ho_q != 16'd0)) begin
            ho_d = ho_q - 16'd1;
        end
`endif

        // Every entry into ARMED restarts the trigger-wait bookkeeping.
        if ((state_d == S_ARMED) && (state_q != S_ARMED)) begin
            to_d   = '0;
            pend_d = 1'b0;
`ifdef DSO_ACQ_HOLDOFF_EN
            ho_d   = holdoff;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pre_len_q   <= '0;
            single_q    <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            pend_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            rd_base_q   <= '0;
            frame_rdy_q <= 1'b0;
            trig_auto_q <= 1'b0;
`ifdef DSO_ACQ_HOLDOFF_EN
            ho_q        <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            pre_len_q   <= pre_len_d;
            single_q    <= single_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            pend_q      <= pend_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            rd_base_q   <= rd_base_d;
            frame_rdy_q <= frame_rdy_d;
            trig_auto_q <= trig_auto_d;
`ifdef DSO_ACQ_HOLDOFF_EN
            ho_q        <= ho_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign trig_addr = trig_addr_q;
    assign rd_base   = rd_base_q;
    assign frame_rdy = frame_rdy_q;
    assign trig_auto = trig_auto_q;
    assign acq_state = state_q;

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Self-checking bench for dso_acq_ctrl: directed scenarios with randomized sample timing
// against a frame-level reference model (sample indices, trigger index, armed-cycle count).
module tb_dso_acq_ctrl;

    localparam int unsigned ADDR_W  = 9;
    localparam int          DEPTH   = 512;
    localparam int          AUTO_TO = 1000;

    logic              clk, rstn, wave_run, single, auto_en, smp_vld, trig_in, rd_over;
    logic [ADDR_W-1:0] pre_len;
    logic              wr_en, frame_rdy, trig_auto;
    logic [ADDR_W-1:0] wr_addr, trig_addr, rd_base;
    logic [2:0]        acq_state;

    int n_cmp, n_bad;

    // Reference model: frame progress expressed as sample counts.
    bit m_act, m_hold, m_frdy, m_single, m_tauto;
    int m_pre, m_k, m_tk, m_acyc;
    int wr_cnt, last_addr;

    dso_acq_ctrl #(.ADDR_W(ADDR_W), .AUTO_TO(AUTO_TO), .TO_W(20)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wave_run  (wave_run),
        .single    (single),
        .auto_en   (auto_en),
        .pre_len   (pre_len),
        .smp_vld   (smp_vld),
        .trig_in   (trig_in),
`ifdef DSO_ACQ_HOLDOFF_EN
        .holdoff   (16'd0),
`endif
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .trig_addr (trig_addr),
        .rd_base   (rd_base),
        .frame_rdy (frame_rdy),
        .rd_over   (rd_over),
        .trig_auto (trig_auto),
        .acq_state (acq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_act = 0; m_hold = 0; m_frdy = 0; m_single = 0; m_tauto = 0;
        m_pre = 0; m_k = 0; m_tk = -1; m_acyc = 0;
    endtask

    task automatic m_arm();
        m_pre    = (int'(pre_len) > DEPTH - 2) ? DEPTH - 2 : int'(pre_len);
        m_single = !wave_run;
        m_k      = 0;
        m_tk     = -1;
        m_acyc   = 0;
        m_act    = 1;
    endtask

    // One clock: drive inputs at negedge, advance model, check outputs at following negedge.
    task automatic step(input logic sv, input logic ti, input logic rdo);
        bit exp_wr, in_armed;
        int exp_addr, exp_state;
        smp_vld = sv; trig_in = ti; rd_over = rdo;
        exp_wr = 0; exp_addr = 0;
        if (m_hold) begin
            if (rdo) begin
                m_frdy = 0; m_hold = 0;
                if (wave_run && !m_single) m_arm();
            end
        end else if (!m_act) begin
            if (wave_run || single) m_arm();
        end else if (!wave_run && !m_single && m_tk < 0) begin
            m_act = 0;
        end else begin
            in_armed = (m_k >= m_pre) && (m_tk < 0);
            if (sv) begin
                exp_wr   = 1;
                exp_addr = m_k % DEPTH;
                if (in_armed && (ti || (auto_en && m_acyc >= AUTO_TO))) begin
                    m_tk    = m_k;
                    m_tauto = !ti;
                end
                m_k++;
                if (m_tk >= 0 && m_k == m_tk + DEPTH - m_pre) begin
                    m_act = 0; m_hold = 1; m_frdy = 1;
                end
            end
            if (in_armed) m_acyc++;
        end
        if (m_hold)             exp_state = 4;
        else if (!m_act)        exp_state = 0;
        else if (m_k < m_pre)   exp_state = 1;
        else if (m_tk < 0)      exp_state = 2;
        else                    exp_state = 3;

        @(posedge clk);
        @(negedge clk);
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
        chk("frame_rdy", 32'(frame_rdy), 32'(m_frdy));
        chk("acq_state", 32'(acq_state), 32'(exp_state));
        if (m_frdy) begin
            chk("trig_addr", 32'(trig_addr), 32'(m_tk % DEPTH));
            chk("rd_base", 32'(rd_base), 32'((m_tk - m_pre) % DEPTH));
            chk("trig_auto", 32'(trig_auto), 32'(m_tauto));
        end
        if (wr_en === 1'b1) begin
            wr_cnt++;
            last_addr = int'(wr_addr);
        end
    endtask

    // Run until the model reports the frame locked; ta/tb are sample indices carrying trig_in.
    task automatic run_frame(input int ta, input int tb, input bit dense, input int budget);
        int  n;
        logic sv, ti;
        n = 0;
        wr_cnt = 0;
        while (!m_hold && n < budget) begin
            sv = dense ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            if (sv) ti = (m_k == ta) || (m_k == tb);
            else    ti = 1'($urandom_range(0, 1));
            single = 1'($urandom_range(0, 7) == 0);
            step(sv, ti, 1'b0);
            pre_len = ADDR_W'($urandom);
            n++;
        end
        single = 1'b0;
        chk("frame_done", 32'(frame_rdy), 32'(1));
    endtask

    task automatic release_frame(input int hold_cyc);
        repeat (hold_cyc) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int n, pl, pq;
        n_cmp = 0; n_bad = 0; wr_cnt = 0; last_addr = 0;
        rstn = 1'b0; wave_run = 1'b0; single = 1'b0; auto_en = 1'b0;
        pre_len = '0; smp_vld = 1'b0; trig_in = 1'b0; rd_over = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_trig_addr", 32'(trig_addr), 0);
        chk("rst_rd_base", 32'(rd_base), 0);
        chk("rst_frame_rdy", 32'(frame_rdy), 0);
        chk("rst_trig_auto", 32'(trig_auto), 0);
        chk("rst_acq_state", 32'(acq_state), 0);
        rstn = 1'b1;

        // Normal capture: pre 100, trigger at sample 300.
        wave_run = 1'b1; pre_len = 9'd100; auto_en = 1'b0;
        run_frame(-1, 300, 1'b1, 3000);
        chk("norm_writes", 32'(wr_cnt), 712);
        chk("norm_last_addr", 32'(last_addr), 199);
        chk("norm_trig_addr", 32'(trig_addr), 300);
        chk("norm_rd_base", 32'(rd_base), 200);
        chk("norm_trig_auto", 32'(trig_auto), 0);

        // Early trigger in pre-fill is ignored; first armed sample triggers.
        pre_len = 9'd100;
        release_frame(5);
        run_frame(50, 100, 1'b1, 3000);
        chk("early_trig_addr", 32'(trig_addr), 100);
        chk("early_rd_base", 32'(rd_base), 0);
        chk("early_writes", 32'(wr_cnt), 512);

        // Auto trigger after AUTO_TO armed cycles.
        pre_len = 9'd100; auto_en = 1'b1;
        release_frame(2);
        run_frame(-1, -1, 1'b1, 4000);
        chk("auto_trig_auto", 32'(trig_auto), 1);
        chk("auto_trig_addr", 32'(trig_addr), 76);
        chk("auto_rd_base", 32'(rd_base), 488);
        chk("auto_writes", 32'(wr_cnt), 1512);
        chk("auto_last_addr", 32'(last_addr), 487);

        // Randomized continuous frames, including clamp (511->510) and zero pre-length.
        for (int f = 0; f < 5; f++) begin
            pl = (f == 0) ? 511 : (f == 1) ? 0 : int'($urandom_range(1, 509));
            pq = (pl > DEPTH - 2) ? DEPTH - 2 : pl;
            pre_len = ADDR_W'(pl);
            auto_en = 1'($urandom_range(0, 1));
            release_frame(int'($urandom_range(0, 6)));
            run_frame(int'($urandom_range(0, pq)), pq + int'($urandom_range(0, 600)), 1'b0, 8000);
            chk("rand_writes", 32'(wr_cnt), 32'(m_tk + DEPTH - m_pre));
        end

        // Stop while armed: abort to IDLE, no write, rd_over ignored afterwards.
        auto_en = 1'b0; pre_len = 9'd20;
        release_frame(3);
        n = 0;
        while (m_k < 25 && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("stop_pre_state", 32'(acq_state), 2);
        wave_run = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("stop_state", 32'(acq_state), 0);
        chk("stop_wr_en", 32'(wr_en), 0);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("stop_frame_rdy", 32'(frame_rdy), 0);

        // Single shot, then long quiet period.
        pre_len = 9'd100; single = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        single = 1'b0;
        chk("single_armed", 32'(acq_state), 1);
        run_frame(-1, 300, 1'b1, 3000);
        chk("single_writes", 32'(wr_cnt), 712);
        chk("single_trig_addr", 32'(trig_addr), 300);
        release_frame(4);
        chk("single_idle", 32'(acq_state), 0);
        wr_cnt = 0;
        repeat (5000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("single_quiet", 32'(wr_cnt), 0);

        // Asynchronous reset in the middle of POST.
        wave_run = 1'b1; pre_len = 9'd100;
        step(1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(m_tk >= 0 && m_k >= m_tk + 50) && n < 2000) begin
            step(1'b1, (m_k == 150), 1'b0);
            n++;
        end
        chk("mid_post_state", 32'(acq_state), 3);
        rstn = 1'b0; wave_run = 1'b0; smp_vld = 1'b0; trig_in = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_frame_rdy", 32'(frame_rdy), 0);
        chk("arst_acq_state", 32'(acq_state), 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wr_cnt = 0;
        repeat (50) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("arst_no_writes", 32'(wr_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dso_acq_ctrl.md
Name: dso_acq_ctrl

Overview:
Acquisition sequencer for the DSO capture path. It arms the sample RAM, fills the pre-trigger region, waits for a trigger (real or auto), and completes the post-trigger region. It then locks the buffer for the HDMI waveform reader and waits for that reader's read-done pulse before re-arming. It sits between the decimator/trigger detector and the wave RAM write port, in the `clk` domain. The display handshake is synchronised into `clk` upstream.

Parameters:
- ADDR_W, 9, wave RAM address width; DEPTH = 2^ADDR_W samples.
- AUTO_TO, 1_000_000, `clk` cycles in ARMED without a trigger before an auto trigger.
- TO_W, 20, width of the auto-timeout counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- wave_run  in  1  1 = continuous acquisition; 0 = stop/single mode
- single  in  1  single-shot arm pulse; honoured only in IDLE with wave_run=0
- auto_en  in  1  enable auto trigger
- pre_len  in  ADDR_W  pre-trigger sample count; sampled on arm
- smp_vld  in  1  decimated sample strobe
- trig_in  in  1  trigger-detect pulse; qualified by smp_vld
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- trig_addr  out  ADDR_W  address of the trigger sample
- rd_base  out  ADDR_W  display start address = trig_addr - pre_len_q (mod DEPTH)
- frame_rdy  out  1  buffer locked, display may read
- rd_over  in  1  display read-done pulse
- trig_auto  out  1  last frame was auto-triggered
- acq_state  out  3  current state encoding

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous and applies at any time, including mid-frame.
- State encoding: IDLE=0, PRE_FILL=1, ARMED=2, POST=3, HOLD=4.
- Write timing:
  - wr_en and wr_addr are registered, one cycle after the smp_vld that carries the sample.
  - The sample counter resets to 0 on arm; sample k is written to address k mod DEPTH. The address wraps naturally.
- Arm:
  - Condition: IDLE and (wave_run=1 or single=1).
  - Actions: latch pre_len_q = min(pre_len, DEPTH-2); latch the single-mode flag; go to PRE_FILL.
  - If pre_len_q = 0, go straight to ARMED.
- PRE_FILL:
  - Each smp_vld writes one sample.
  - After pre_len_q writes, go to ARMED.
  - trig_in is ignored.
- ARMED:
  - Keeps writing circularly.
  - A trigger is smp_vld & trig_in. That sample is written; trig_addr is set to its address; go to POST; trig_auto=0.
  - The timeout counter runs on every `clk` cycle in ARMED.
  - At AUTO_TO with auto_en=1: set auto-pending. The next smp_vld is taken as the trigger, with trig_auto=1.
  - The timeout counter clears when ARMED is entered.
- POST:
  - Writes DEPTH-1-pre_len_q further samples, then goes to HOLD.
  - frame_rdy=1 in the same cycle as the last wr_en.
  - rd_base is valid from that cycle.
- HOLD:
  - wr_en=0.
  - On rd_over: frame_rdy=0 next cycle.
  - Then re-arm to PRE_FILL if wave_run=1 and not single mode; otherwise go to IDLE.
- wave_run falls in PRE_FILL or ARMED (continuous mode): abort to IDLE next cycle; frame_rdy stays 0. In POST, the frame completes.
- single pulses with wave_run=1, or outside IDLE: ignored.
- rd_over outside HOLD: ignored.
- trig_in without smp_vld: ignored.
- pre_len changes mid-frame: no effect until the next arm.

Optional Feature:
- Macro: DSO_ACQ_HOLDOFF_EN.
- With the macro defined:
  - Adds input holdoff[15:0].
  - On entering ARMED, a holdoff counter loads holdoff; triggers are ignored while it is nonzero.
  - The auto timeout starts only after holdoff expires.
- Without the macro: the port is absent and triggers are accepted on the first ARMED sample.

Test Plan:
- Reset: assert rstn=0 mid-POST -> wr_en=0, frame_rdy=0, acq_state=0 immediately; no writes after release until the next arm.
- Normal capture:
  - Stimulus: ADDR_W=9, wave_run=1, pre_len=100, smp_vld every cycle, trig_in at sample 300.
  - Required: trig_addr=300, rd_base=200, 712 total writes, last write to addr 199, frame_rdy=1 with it, trig_auto=0.
- Early trigger: trig_in at sample 50 (PRE_FILL) ignored; trig_in at sample 100 -> trig_addr=100, rd_base=0.
- Auto trigger: AUTO_TO=1000, auto_en=1, no trig_in -> trigger taken on the first smp_vld after 1000 ARMED cycles; trig_auto=1; frame completes.
- Single shot: wave_run=0, one single pulse, trig at sample 300 -> one frame; rd_over -> IDLE; no further wr_en for 5000 cycles.
- Stop in ARMED: drop wave_run in ARMED -> IDLE next cycle; wr_en=0; frame_rdy stays 0; rd_over pulse then causes no change.
